// File: rtl/ste_dma_sound_ctrl.sv
// STE DMA sound sequencer: CPU-visible frame registers plus the fetch/load
// state machine that feeds one memory word per granted slot to the shifter FIFO.
module ste_dma_sound_ctrl #(
  parameter int AW        = 22,
  parameter int SLOAD_LEN = 2
) (
  input  logic          clk32,
  input  logic          resb,
  input  logic          CS,
  input  logic          RW,
  input  logic [3:0]    A,
  input  logic [15:0]   DIN,
  output logic [15:0]   DOUT,
  input  logic          SREQ,
  input  logic          slot,
  output logic          snd_rd,
  output logic [AW-1:0] snd_addr,
  input  logic          snd_ack,
  output logic          SLOAD_N,
  output logic          frame_end,
  output logic          active
);

  localparam int LW = (SLOAD_LEN > 1) ? $clog2(SLOAD_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FETCH, LOAD} state_t;

  state_t        state;
  logic          cs_d;
  logic          play, loop_en;
  logic [7:0]    st_hi, st_mid, en_hi, en_mid;
  logic [6:0]    st_lo, en_lo;
  logic [AW-1:0] counter, end_l;
  logic [LW-1:0] load_cnt;

  logic          wr, arm;
  logic [AW-1:0] start_w, end_w, cnt_inc;
  logic [23:0]   cnt_b;
  logic [7:0]    rd_b;
  logic          unused_din;

  // Writes fire once per CS assertion, however long the CPU holds CS.
  assign wr         = CS & ~cs_d & ~RW;
  assign arm        = wr && (A == 4'd0) && DIN[0] && !play && (state == IDLE);
  assign start_w    = AW'({st_hi, st_mid, st_lo});
  assign end_w      = AW'({en_hi, en_mid, en_lo});
  assign cnt_inc    = counter + AW'(1);
  assign cnt_b      = 24'({counter, 1'b0});
  assign unused_din = ^DIN[15:8];

  always_comb begin
    rd_b = 8'h00;
    case (A)
      4'd0: rd_b = {6'b0, loop_en, play};
      4'd1: rd_b = st_hi;
      4'd2: rd_b = st_mid;
      4'd3: rd_b = {st_lo, 1'b0};
      4'd4: rd_b = cnt_b[23:16];
      4'd5: rd_b = cnt_b[15:8];
      4'd6: rd_b = cnt_b[7:0];
      4'd7: rd_b = en_hi;
      4'd8: rd_b = en_mid;
      4'd9: rd_b = {en_lo, 1'b0};
      default: rd_b = 8'h00;
    endcase
  end

  assign DOUT = {8'h00, rd_b};

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state     <= IDLE;
      cs_d      <= 1'b0;
      play      <= 1'b0;
      loop_en   <= 1'b0;
      st_hi     <= '0;
      st_mid    <= '0;
      st_lo     <= '0;
      en_hi     <= '0;
      en_mid    <= '0;
      en_lo     <= '0;
      counter   <= '0;
      end_l     <= '0;
      load_cnt  <= '0;
      snd_rd    <= 1'b0;
      snd_addr  <= '0;
      SLOAD_N   <= 1'b1;
      frame_end <= 1'b0;
      active    <= 1'b0;
    end else begin
      cs_d      <= CS;
      frame_end <= 1'b0;

      if (wr) begin
        case (A)
          4'd0: begin play <= DIN[0]; loop_en <= DIN[1]; end
          4'd1: st_hi  <= DIN[7:0];
          4'd2: st_mid <= DIN[7:0];
          4'd3: st_lo  <= DIN[7:1];
          4'd7: en_hi  <= DIN[7:0];
          4'd8: en_mid <= DIN[7:0];
          4'd9: en_lo  <= DIN[7:1];
          default: ;
        endcase
      end

      // FSM updates come after the CPU write so that its play clears win.
      case (state)
        IDLE: begin
          if (arm) begin
            counter <= start_w;
            end_l   <= end_w;
            if (start_w >= end_w) begin
              play      <= 1'b0;
              frame_end <= 1'b1;
            end else begin
              state  <= RUN;
              active <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!play) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (SREQ && slot) begin
            state    <= FETCH;
            snd_rd   <= 1'b1;
            snd_addr <= counter;
          end
        end
        FETCH: begin
          if (snd_ack) begin
            snd_rd   <= 1'b0;
            SLOAD_N  <= 1'b0;
            load_cnt <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt == LW'(SLOAD_LEN - 1)) begin
            SLOAD_N <= 1'b1;
            counter <= cnt_inc;
            if (cnt_inc == end_l) begin
              frame_end <= 1'b1;
              if (loop_en && play) begin
                counter <= start_w;
                end_l   <= end_w;
                state   <= RUN;
              end else begin
                play   <= 1'b0;
                state  <= IDLE;
                active <= 1'b0;
              end
            end else if (play) begin
              state <= RUN;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
            end
          end else begin
            load_cnt <= load_cnt + LW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_dma_sound_ctrl.sv
// Bench for ste_dma_sound_ctrl: scoreboard of expected fetch addresses, slot and
// ack responders, and a monitor counting load strobes and frame-end pulses.
module tb_ste_dma_sound_ctrl;
  localparam int AW = 22;

  logic          clk32 = 1'b0;
  logic          resb, CS, RW, SREQ, slot, snd_ack;
  logic [3:0]    A;
  logic [15:0]   DIN, DOUT;
  logic          snd_rd, SLOAD_N, frame_end, active;
  logic [AW-1:0] snd_addr;

  int n_tests = 0, n_fail = 0;
  int fetch_cnt = 0, loads = 0, fe_cnt = 0, lo_len = 0;
  logic slot_en = 1'b0, ack_en = 1'b0, rd_prev = 1'b0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_a;

  ste_dma_sound_ctrl #(.AW(AW), .SLOAD_LEN(2)) dut (
    .clk32(clk32), .resb(resb), .CS(CS), .RW(RW), .A(A), .DIN(DIN), .DOUT(DOUT),
    .SREQ(SREQ), .slot(slot), .snd_rd(snd_rd), .snd_addr(snd_addr),
    .snd_ack(snd_ack), .SLOAD_N(SLOAD_N), .frame_end(frame_end), .active(active)
  );

  always #5 clk32 = ~clk32;

  initial begin
    int ph;
    ph = 0;
    slot = 1'b0;
    forever begin
      @(negedge clk32);
      slot = slot_en && (ph == 0);
      ph = (ph == 19) ? 0 : ph + 1;
    end
  end

  // Memory model: data valid three cycles after the request is seen.
  initial begin
    snd_ack = 1'b0;
    forever begin
      @(negedge clk32);
      if (snd_rd === 1'b1 && ack_en) begin
        repeat (2) @(negedge clk32);
        snd_ack = 1'b1;
        @(negedge clk32);
        snd_ack = 1'b0;
      end
    end
  end

  always @(negedge clk32) begin
    if (snd_rd === 1'b1 && !rd_prev) begin
      fetch_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_addr: unexpected read at %h, none expected", snd_addr);
      end else begin
        exp_a = exp_q.pop_front();
        if (snd_addr !== exp_a) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h expected %h", snd_addr, exp_a);
        end
      end
    end
    rd_prev = (snd_rd === 1'b1);
    if (frame_end === 1'b1) fe_cnt++;
    if (SLOAD_N === 1'b0) lo_len++;
    else if (lo_len > 0) begin
      n_tests++;
      loads++;
      if (lo_len != 2) begin
        n_fail++;
        $display("FAIL sload_len: got %0d cycles expected 2", lo_len);
      end
      lo_len = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failed", n_fail);
    $fatal(1);
  end

  task automatic cpu_wr(input logic [3:0] idx, input logic [7:0] d);
    @(negedge clk32);
    CS = 1'b1; RW = 1'b0; A = idx; DIN = {8'h00, d};
    @(negedge clk32);
    CS = 1'b0; RW = 1'b1;
  endtask

  task automatic cpu_rd(input logic [3:0] idx, output logic [7:0] d);
    A = idx;
    #1 d = DOUT[7:0];
  endtask

  task automatic rd24(input logic [3:0] base, output logic [23:0] v);
    logic [7:0] b0, b1, b2;
    cpu_rd(base, b0);
    cpu_rd(base + 4'd1, b1);
    cpu_rd(base + 4'd2, b2);
    v = {b0, b1, b2};
  endtask

  task automatic set_frame(input logic [23:0] s, input logic [23:0] e);
    cpu_wr(4'd1, s[23:16]); cpu_wr(4'd2, s[15:8]); cpu_wr(4'd3, s[7:0]);
    cpu_wr(4'd7, e[23:16]); cpu_wr(4'd8, e[15:8]); cpu_wr(4'd9, e[7:0]);
  endtask

  task automatic clear_counts();
    fetch_cnt = 0; loads = 0; fe_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] b;
    resb = 1'b1; CS = 1'b0; RW = 1'b1; A = 4'd0; DIN = '0; SREQ = 1'b0;
    #1 resb = 1'b0;
    repeat (3) @(negedge clk32);
    n_tests++;
    if ({snd_rd, SLOAD_N, frame_end, active} !== 4'b0100 || snd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd/sload/fe/act=%b addr=%h expected 0100 addr 0",
               {snd_rd, SLOAD_N, frame_end, active}, snd_addr);
    end
    cpu_rd(4'd0, b);
    n_tests++;
    if (DOUT !== 16'h0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 0000", DOUT);
    end
    @(negedge clk32);
    resb = 1'b1;
  endtask

  task automatic test_reset_in_fetch();
    logic [7:0] b;
    logic [23:0] v;
    clear_counts();
    set_frame(24'h010000, 24'h010006);
    exp_q.push_back(22'h008000);
    ack_en = 1'b0; SREQ = 1'b1; slot_en = 1'b1;
    cpu_wr(4'd0, 8'h01);
    for (int i = 0; i < 100 && fetch_cnt < 1; i++) @(negedge clk32);
    n_tests++;
    if (snd_rd !== 1'b1 || active !== 1'b1) begin
      n_fail++; $display("FAIL fetch_pending: got rd=%b act=%b expected 1 1", snd_rd, active);
    end
    #2 resb = 1'b0;
    #1;
    n_tests++;
    if ({snd_rd, SLOAD_N, active} !== 3'b010) begin
      n_fail++; $display("FAIL async_reset: got rd/sload/act=%b expected 010", {snd_rd, SLOAD_N, active});
    end
    cpu_rd(4'd0, b);
    n_tests++;
    if (b !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl_reg: got %h expected 00", b); end
    rd24(4'd1, v);
    n_tests++;
    if (v !== 24'h0) begin n_fail++; $display("FAIL reset_start: got %h expected 000000", v); end
    rd24(4'd4, v);
    n_tests++;
    if (v !== 24'h0) begin n_fail++; $display("FAIL reset_counter: got %h expected 000000", v); end
    rd24(4'd7, v);
    n_tests++;
    if (v !== 24'h0) begin n_fail++; $display("FAIL reset_end: got %h expected 000000", v); end
    @(negedge clk32);
    resb = 1'b1; SREQ = 1'b0; slot_en = 1'b0;
    repeat (3) @(negedge clk32);
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    logic [23:0] v;
    clear_counts();
    set_frame(24'h010000, 24'h010006);
    exp_q.push_back(22'h008000); exp_q.push_back(22'h008001); exp_q.push_back(22'h008002);
    ack_en = 1'b1; SREQ = 1'b1; slot_en = 1'b1;
    cpu_wr(4'd0, 8'h01);
    for (int i = 0; i < 400 && fe_cnt < 1; i++) @(negedge clk32);
    repeat (30) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 3 || loads != 3 || fe_cnt != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL single_frame: got fetch=%0d loads=%0d fe=%0d left=%0d expected 3 3 1 0",
               fetch_cnt, loads, fe_cnt, exp_q.size());
    end
    cpu_rd(4'd0, b);
    n_tests++;
    if (b !== 8'h00 || active !== 1'b0) begin
      n_fail++; $display("FAIL single_stop: got ctrl=%h act=%b expected 00 0", b, active);
    end
    rd24(4'd4, v);
    n_tests++;
    if (v !== 24'h010006) begin n_fail++; $display("FAIL single_counter: got %h expected 010006", v); end
    A = 4'd1;
    #1;
    n_tests++;
    if (DOUT !== 16'h0001) begin n_fail++; $display("FAIL start_hi_read: got %h expected 0001", DOUT); end
    A = 4'd12;
    #1;
    n_tests++;
    if (DOUT !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0000", DOUT); end
  endtask

  task automatic test_loop();
    logic [7:0] b;
    clear_counts();
    set_frame(24'h010000, 24'h010006);
    exp_q.push_back(22'h008000); exp_q.push_back(22'h008001); exp_q.push_back(22'h008002);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(22'h008000); exp_q.push_back(22'h008001);
    end
    cpu_wr(4'd0, 8'h03);
    for (int i = 0; i < 100 && fetch_cnt < 1; i++) @(negedge clk32);
    cpu_wr(4'd9, 8'h04);
    for (int i = 0; i < 1000 && fe_cnt < 3; i++) @(negedge clk32);
    cpu_wr(4'd0, 8'h02);
    repeat (40) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 7 || loads != 7 || fe_cnt != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL loop_frames: got fetch=%0d loads=%0d fe=%0d left=%0d expected 7 7 3 0",
               fetch_cnt, loads, fe_cnt, exp_q.size());
    end
    cpu_rd(4'd0, b);
    n_tests++;
    if (b !== 8'h02 || active !== 1'b0) begin
      n_fail++; $display("FAIL loop_stop: got ctrl=%h act=%b expected 02 0", b, active);
    end
    cpu_wr(4'd0, 8'h00);
  endtask

  task automatic test_sreq_gate();
    clear_counts();
    set_frame(24'h010000, 24'h010006);
    SREQ = 1'b0; slot_en = 1'b1;
    cpu_wr(4'd0, 8'h01);
    repeat (60) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 0 || active !== 1'b1) begin
      n_fail++; $display("FAIL sreq_low: got fetch=%0d act=%b expected 0 1", fetch_cnt, active);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk32);
      if (slot === 1'b1) break;
    end
    @(negedge clk32);
    exp_q.push_back(22'h008000); exp_q.push_back(22'h008001); exp_q.push_back(22'h008002);
    SREQ = 1'b1;
    repeat (15) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 0) begin
      n_fail++; $display("FAIL sreq_early: got fetch=%0d expected 0 before next slot", fetch_cnt);
    end
    repeat (10) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 1) begin
      n_fail++; $display("FAIL sreq_next_slot: got fetch=%0d expected 1", fetch_cnt);
    end
    for (int i = 0; i < 300 && fe_cnt < 1; i++) @(negedge clk32);
    repeat (10) @(negedge clk32);
    n_tests++;
    if (fetch_cnt != 3 || fe_cnt != 1 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL sreq_frame: got fetch=%0d fe=%0d act=%b expected 3 1 0", fetch_cnt, fe_cnt, active);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] b;
    clear_counts();
    set_frame(24'h020000, 24'h020000);
    SREQ = 1'b1; slot_en = 1'b1;
    cpu_wr(4'd0, 8'h03);
    repeat (60) @(negedge clk32);
    cpu_rd(4'd0, b);
    n_tests++;
    if (fetch_cnt != 0 || fe_cnt != 1 || b !== 8'h02 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len: got fetch=%0d fe=%0d ctrl=%h act=%b expected 0 1 02 0",
               fetch_cnt, fe_cnt, b, active);
    end
    cpu_wr(4'd0, 8'h00);
  endtask

  task automatic test_stop_in_fetch();
    logic [7:0] b;
    logic [23:0] v;
    clear_counts();
    set_frame(24'h010000, 24'h010006);
    exp_q.push_back(22'h008000);
    ack_en = 1'b0; SREQ = 1'b1; slot_en = 1'b1;
    cpu_wr(4'd0, 8'h01);
    for (int i = 0; i < 100 && fetch_cnt < 1; i++) @(negedge clk32);
    cpu_wr(4'd0, 8'h00);
    repeat (3) @(negedge clk32);
    n_tests++;
    if (snd_rd !== 1'b1) begin
      n_fail++; $display("FAIL stop_hold_rd: got rd=%b expected 1", snd_rd);
    end
    ack_en = 1'b1;
    repeat (80) @(negedge clk32);
    rd24(4'd4, v);
    cpu_rd(4'd0, b);
    n_tests++;
    if (loads != 1 || fetch_cnt != 1 || fe_cnt != 0 || active !== 1'b0 || snd_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_in_fetch: got loads=%0d fetch=%0d fe=%0d act=%b rd=%b expected 1 1 0 0 0",
               loads, fetch_cnt, fe_cnt, active, snd_rd);
    end
    n_tests++;
    if (v !== 24'h010002 || b !== 8'h00) begin
      n_fail++; $display("FAIL stop_counter: got cnt=%h ctrl=%h expected 010002 00", v, b);
    end
    SREQ = 1'b0; slot_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_in_fetch();
    test_single_frame();
    test_loop();
    test_sreq_gate();
    test_zero_len();
    test_stop_in_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ste_dma_sound_ctrl.md
Name: ste_dma_sound_ctrl

Overview:
- Sequences STE DMA sound fetches for the shifter's audio FIFO.
- Holds the CPU-visible frame start, frame end, counter and control registers.
- Reacts to the shifter's SREQ: requests one memory word per granted memory slot, then strobes SLOAD_N so the shifter captures MDIN.
- Signals frame end (interrupt/timer-A event) and handles loop and stop.

Parameters:
- AW, 22, word-address width (byte address bits AW:1).
- SLOAD_LEN, 2, number of clk32 cycles SLOAD_N is held low per loaded word.

Ports:
- clk32  in  1  system clock.
- resb  in  1  reset; asynchronous, active-low.
- CS  in  1  sound register chip select.
- RW  in  1  1=read, 0=write.
- A  in  4  register word index, A[4:1].
- DIN  in  16  CPU write data; low byte used.
- DOUT  out  16  register read data; high byte always 0.
- SREQ  in  1  shifter FIFO not full.
- slot  in  1  one-cycle pulse: memory slot free for sound.
- snd_rd  out  1  memory read request.
- snd_addr  out  AW  word address of the read.
- snd_ack  in  1  one-cycle pulse: read data valid on MDIN.
- SLOAD_N  out  1  active-low load strobe to the shifter.
- frame_end  out  1  one-cycle pulse at end of frame.
- active  out  1  1 while playback is running (state != IDLE).

Behaviour:
- Register write accepted only on the first cycle of CS & ~RW, i.e. on the rising edge of CS, using a registered CS_d.
- Register map, byte data in DIN[7:0]:
  - 0 ctrl: bit0 play, bit1 loop.
  - 1/2/3 start hi/mid/lo: address bits 23:16 / 15:8 / 7:1; DIN[0] ignored.
  - 4/5/6 counter, read-only.
  - 7/8/9 end, same layout as start.
  - Reads of other indices return 0.
- Reset (async): all registers 0, state IDLE, snd_rd=0, SLOAD_N=1, frame_end=0, active=0, snd_addr=0.
- States IDLE, RUN, FETCH, LOAD.
  - IDLE: when play is written 0→1, latch counter<=start and end_l<=end, then go to RUN next cycle.
    - Zero-length frame (start>=end at arm): no fetch, frame_end pulse, play cleared, stay IDLE, regardless of loop.
  - RUN: if play=0, go to IDLE. Else if SREQ & slot in the same cycle, go to FETCH; snd_rd=1 and snd_addr=counter from the next cycle. slot without SREQ is ignored.
  - FETCH: hold snd_rd and snd_addr until snd_ack. On snd_ack: snd_rd=0, SLOAD_N=0 next cycle, go to LOAD.
  - LOAD: SLOAD_N low for exactly SLOAD_LEN cycles, then high. On the last LOAD cycle, counter<=counter+1 (wraps modulo 2^AW).
    - If counter+1==end_l: frame_end pulses one cycle.
      - If loop=1: reload counter<=start, end_l<=end (current register values) and go to RUN.
      - If loop=0: clear play and go to IDLE.
    - Otherwise go to RUN.
- CPU clearing play during FETCH/LOAD: the current word completes (ack and SLOAD_N strobe, counter advance), then IDLE. No new fetch is issued.
- Start/end writes during playback do not affect the running frame; they take effect at the next arm or loop reload.
- Writing play=1 while already active has no effect (no re-arm).
- Counter readback is live.

Test Plan:
- Reset during FETCH (snd_rd=1): resb low → snd_rd=0, SLOAD_N=1, active=0 immediately (asynchronously); all registers read 0.
- start=0x010000, end=0x010006, loop=0, play=1; SREQ=1, slot every 20 cycles, ack 3 cycles after snd_rd:
  - snd_addr sequence 0x8000, 0x8001, 0x8002 (word addresses).
  - 3 SLOAD_N pulses, each 2 cycles long.
  - One frame_end pulse after the 3rd load; play reads 0; active=0.
- Same frame with loop=1, end rewritten to 0x010004 mid-frame: first frame 3 words; frame_end; next frame 2 words (0x8000, 0x8001); repeats.
- SREQ=0 with slots arriving → no snd_rd. Raise SREQ → fetch starts on the next slot only.
- start=end=0x020000, play=1 → no snd_rd, frame_end pulse, play=0.
- Clear play during FETCH → ack completes; one SLOAD_N strobe; counter +1; IDLE; no further snd_rd even with SREQ and slot.
